// File: rtl/exception_sequencer.sv
// exception_sequencer: multicycle exception entry (Cause/EPC write, handler fetch, PC load).
// Sits beside the main control unit, which stalls while busy is high.
module exception_sequencer #(
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data_in,
    output logic [1:0]  cause_sel,
    output logic        cause_write,
    output logic        epc_write,
    output logic [31:0] epc_value,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic        pc_write,
    output logic [31:0] pc_value,
    output logic        busy,
    output logic        nested_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT, LOAD} state_t;
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);
    state_t      state, next;
    logic [1:0]  sel;
    logic [31:0] pc_lat;
    logic [3:0]  cnt;
    logic [7:0]  data;
    logic        req;
    assign req = exc_opcode | exc_overflow | exc_divzero;
    assign cause_sel = sel;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 2'b00;
            pc_lat     <= '0;
            cnt        <= '0;
            data       <= '0;
            nested_err <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && req) begin
                sel    <= exc_opcode ? 2'b00 : exc_overflow ? 2'b01 : 2'b10;
                pc_lat <= pc_in;
            end
            cnt <= state == CAPTURE ? LAT : state == WAIT ? cnt - 4'd1 : cnt;
            if (state == WAIT && cnt == 4'd1)
                data <= mem_data_in;
            if (state != IDLE && req)
                nested_err <= 1'b1;
        end
    end
    // Strobes are masked while reset is high so an aborted sequence never writes state.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req ? CAPTURE : IDLE;
            CAPTURE: next = WAIT;
            WAIT:    next = cnt == 4'd1 ? LOAD : WAIT;
            default: next = IDLE;
        endcase
        busy        = state != IDLE;
        cause_write = state == CAPTURE && !reset;
        epc_write   = state == CAPTURE && !reset;
        epc_value   = state == CAPTURE ? pc_lat - EPC_OFFSET : '0;
        mem_read    = state == CAPTURE || state == WAIT;
        mem_addr    = mem_read ? 32'd253 + 32'(sel) : '0;
        pc_write    = state == LOAD && !reset;
        pc_value    = state == LOAD ? {24'b0, data} : '0;
    end
endmodule
